// File: rtl/mmio_fabric.sv
// mmio_fabric: decodes CPU accesses in the MMIO window onto one of CHANNELS
// peripheral channels, stalls the CPU until the selected device acknowledges,
// aborts stalled accesses after TIMEOUT cycles and keeps a sticky bus-error flag.
module mmio_fabric #(
   parameter int          CHANNELS  = 4,
   parameter int          OFFSET_W  = 4,
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_FC00,
   parameter int          TIMEOUT   = 16,
   parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
   input  logic                     iCpuClock,
   input  logic                     iCpuReset,
   input  logic                     iReq,
   input  logic                     iWrite,
   input  logic [31:0]              iAddr,
   input  logic [31:0]              iWData,
   output logic [31:0]              oRData,
   output logic                     oDone,
   output logic                     oStall,
   output logic [CHANNELS-1:0]      oDevSel,
   output logic                     oDevWrite,
   output logic [OFFSET_W-1:0]      oDevAddr,
   output logic [31:0]              oDevWData,
   input  logic [CHANNELS*32-1:0]   iDevRData,
   input  logic [CHANNELS-1:0]      iDevAck,
   output logic                     oBusError,
   output logic [4:0]               oErrChannel,
   input  logic                     iErrClear
);

   // Channel-number width and the lowest address bit of the window compare.
   localparam int CB = (CHANNELS > 1) ? $clog2(CHANNELS) : 0;
   localparam int LO = OFFSET_W + 2 + CB;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t              state;
   state_t              nextState;

   logic                inWindow;
   logic                mapped;
   logic [4:0]          reqCh;
   logic [OFFSET_W-1:0] reqOff;
   logic                unusedByteBits;

   logic [4:0]          latchCh;
   logic [7:0]          waitCount;
   logic [7:0]          waitCountNext;

   logic                latchReq;
   logic                captureData;
   logic [31:0]         newRData;
   logic                setErr;
   logic [4:0]          errCh;
   logic                selAck;
   logic [31:0]         selRData;

   // Byte-lane bits play no part in word-addressed peripherals.
   assign unusedByteBits = ^iAddr[1:0];

   // Address decode: window match, channel field and word offset.
   assign inWindow = (iAddr[31:LO] == MMIO_BASE[31:LO]);
   assign reqOff   = iAddr[OFFSET_W+1:2];

   generate
      if (CB > 0) begin : gChField
         assign reqCh = 5'(iAddr[LO-1:OFFSET_W+2]);
      end else begin : gNoChField
         assign reqCh = 5'd0;
      end
   endgenerate

   assign mapped = inWindow && (reqCh < 5'(CHANNELS));

   // Handshake status as seen by the CPU.
   assign oDone  = (state == DONE);
   assign oStall = iReq && !oDone;

   // Pick out the latched channel's ack and read data; other channels are ignored.
   always_comb begin
      selAck   = 1'b0;
      selRData = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (latchCh == 5'(k)) begin
            selAck   = iDevAck[k];
            selRData = iDevRData[k*32 +: 32];
         end
      end
   end

   // One-hot select is decoded from state so it drops the instant reset hits.
   always_comb begin
      oDevSel = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         oDevSel[k] = (state == ACCESS) && (latchCh == 5'(k));
      end
   end

   // Next-state logic and the per-transition side effects.
   always_comb begin
      nextState     = state;
      waitCountNext = waitCount;
      latchReq      = 1'b0;
      captureData   = 1'b0;
      newRData      = '0;
      setErr        = 1'b0;
      errCh         = 5'd0;
      case (state)
         IDLE: begin
            if (iReq) begin
               if (mapped) begin
                  latchReq      = 1'b1;
                  waitCountNext = 8'd0;
                  nextState     = ACCESS;
               end else begin
                  captureData = 1'b1;
                  newRData    = ERR_DATA;
                  setErr      = 1'b1;
                  errCh       = 5'h1F;
                  nextState   = DONE;
               end
            end
         end
         ACCESS: begin
            if (selAck) begin
               captureData = 1'b1;
               newRData    = oDevWrite ? 32'd0 : selRData;
               nextState   = DONE;
            end else if (waitCount == 8'(TIMEOUT - 1)) begin
               captureData = 1'b1;
               newRData    = ERR_DATA;
               setErr      = 1'b1;
               errCh       = latchCh;
               nextState   = DONE;
            end else if (waitCount != 8'hFF) begin
               waitCountNext = waitCount + 8'd1;
            end
         end
         DONE: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge iCpuClock or negedge iCpuReset) begin
      if (!iCpuReset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Latch the decoded request fields that are presented to the device.
   always_ff @(posedge iCpuClock or negedge iCpuReset) begin
      if (!iCpuReset) begin
         latchCh   <= 5'd0;
         oDevAddr  <= '0;
         oDevWrite <= 1'b0;
         oDevWData <= '0;
      end else if (latchReq) begin
         latchCh   <= reqCh;
         oDevAddr  <= reqOff;
         oDevWrite <= iWrite;
         oDevWData <= iWData;
      end
   end

   // Wait counter for the timeout watchdog.
   always_ff @(posedge iCpuClock or negedge iCpuReset) begin
      if (!iCpuReset) begin
         waitCount <= 8'd0;
      end else begin
         waitCount <= waitCountNext;
      end
   end

   // Read data only changes on entry to DONE so it is stable for the CPU.
   always_ff @(posedge iCpuClock or negedge iCpuReset) begin
      if (!iCpuReset) begin
         oRData <= '0;
      end else if (captureData) begin
         oRData <= newRData;
      end
   end

   // Sticky error flag: a new error beats a simultaneous clear.
   always_ff @(posedge iCpuClock or negedge iCpuReset) begin
      if (!iCpuReset) begin
         oBusError   <= 1'b0;
         oErrChannel <= 5'd0;
      end else if (setErr) begin
         oBusError   <= 1'b1;
         oErrChannel <= errCh;
      end else if (iErrClear) begin
         oBusError   <= 1'b0;
      end
   end

endmodule
